// File: rtl/fnd_pkg.sv
// fnd_pkg
// Shared constants and types for the 4-digit common-anode FND blocks.
//   SEG_HEX     : hex nibble -> {a,b,c,d,e,f,g,dp} pattern, active-high, dp=0
//   DIGIT_CODE  : slot index -> active-low digit select code
//   DIGIT_OFF / SEG_OFF : all digits dark
//   state_e     : scan controller states
//   lead_zero_mask : digits to auto-blank for leading zeros, used only when
//                    FND_LEADING_ZERO_BLANK_EN is defined
package fnd_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SCAN  = 1'b1
  } state_e;

  localparam logic [3:0] DIGIT_OFF = 4'hf;
  localparam logic [7:0] SEG_OFF   = 8'h00;

  localparam logic [7:0] SEG_HEX [16] = '{
    8'hfc, 8'h60, 8'hda, 8'hf2, 8'h66, 8'hb6, 8'hbe, 8'he0,
    8'hfe, 8'he6, 8'hee, 8'h3e, 8'h9c, 8'h7a, 8'h9e, 8'h8e
  };

  localparam logic [3:0] DIGIT_CODE [4] = '{4'he, 4'hd, 4'hb, 4'h7};

  // A digit is a leading zero when it and every higher digit are zero.
  // The ones digit always stays visible so a value of zero shows "0".
  function automatic logic [3:0] lead_zero_mask(input logic [15:0] v);
    logic [3:0] m;
    m[3] = (v[15:12] == 4'h0);
    m[2] = m[3] && (v[11:8] == 4'h0);
    m[1] = m[2] && (v[7:4] == 4'h0);
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/fnd_hex_to_seg.sv
// fnd_hex_to_seg
// Combinational hex-to-seven-segment decoder shared by the FND blocks.
//   hex_i : 4-bit hex nibble
//   seg_o : {a,b,c,d,e,f,g,dp}, active-high, dp always 0
module fnd_hex_to_seg
  import fnd_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [7:0] seg_o
);

  assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl
// Scan scheduler for the 4-digit common-anode FND. Sequences the digit
// slots, applies per-digit blanking and a brightness duty, and takes new
// display content through a valid/ready handshake. New content is parked in
// a shadow register and only becomes active at a frame boundary, so a frame
// never mixes old and new digits.
//
// Ports:
//   clkdigit   : scan clock
//   reset      : synchronous, active-high
//   ld_valid   : producer has a load pending
//   ld_ready   : controller can accept a load (shadow empty)
//   ld_value   : four hex nibbles, [3:0] ones ... [15:12] thousands
//   ld_blank   : per-digit blank mask, bit i blanks digit i
//   ld_bright  : duty, digit lit while phase <= ld_bright
//   SEG        : segments {a,b,c,d,e,f,g,dp}, active-high
//   DIGIT      : active-low digit select
//   frame_done : one-cycle pulse after each frame boundary
//
// Build option: define FND_LEADING_ZERO_BLANK_EN to additionally blank
// leading zero digits (digits 3..1); the ones digit is never auto-blanked.
module fnd_scan_ctrl
  import fnd_pkg::*;
#(
  parameter int PH_W = 3,
  parameter int NDIG = 4
) (
  input  logic                clkdigit,
  input  logic                reset,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [4*NDIG-1:0]   ld_value,
  input  logic [NDIG-1:0]     ld_blank,
  input  logic [PH_W-1:0]     ld_bright,
  output logic [7:0]          SEG,
  output logic [NDIG-1:0]     DIGIT,
  output logic                frame_done
);

  localparam int SLOT_W = $clog2(NDIG);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NDIG - 1);

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [PH_W-1:0]     phase_q, phase_d;

  logic [4*NDIG-1:0]   act_value_q, act_value_d;
  logic [NDIG-1:0]     act_blank_q, act_blank_d;
  logic [PH_W-1:0]     act_bright_q, act_bright_d;

  logic [4*NDIG-1:0]   sh_value_q, sh_value_d;
  logic [NDIG-1:0]     sh_blank_q, sh_blank_d;
  logic [PH_W-1:0]     sh_bright_q, sh_bright_d;
  logic                sh_full_q, sh_full_d;

  logic [7:0]          seg_q, seg_d;
  logic [NDIG-1:0]     digit_q, digit_d;
  logic                frame_done_q, frame_done_d;

  logic [3:0]          nibble;
  logic [7:0]          segDecoded;
  logic [NDIG-1:0]     blankEff;
  logic                lit;
  logic                boundary;
  logic                xfer;

  assign nibble = act_value_q[{slot_q, 2'b00} +: 4];

  fnd_hex_to_seg u_hex_to_seg (
    .hex_i (nibble),
    .seg_o (segDecoded)
  );

`ifdef FND_LEADING_ZERO_BLANK_EN
  assign blankEff = act_blank_q | lead_zero_mask(act_value_q);
`else
  assign blankEff = act_blank_q;
`endif

  assign lit      = (phase_q <= act_bright_q) && !blankEff[slot_q];
  assign boundary = (state_q == SCAN) && (slot_q == LAST_SLOT) && (&phase_q);
  assign xfer     = ld_valid && !sh_full_q;

  // Next-state and output decode. Outputs are computed from the current
  // slot/phase and registered, giving one cycle of latency. A transfer can
  // only happen while the shadow is empty, and a swap only while it is full,
  // so the two never collide on the same edge.
  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    phase_d      = phase_q;
    act_value_d  = act_value_q;
    act_blank_d  = act_blank_q;
    act_bright_d = act_bright_q;
    sh_value_d   = sh_value_q;
    sh_blank_d   = sh_blank_q;
    sh_bright_d  = sh_bright_q;
    sh_full_d    = sh_full_q;
    seg_d        = SEG_OFF;
    digit_d      = DIGIT_OFF;
    frame_done_d = 1'b0;

    case (state_q)
      BLANK: begin
        // Nothing is on screen yet, so the first load goes straight to the
        // active registers instead of waiting for a frame boundary.
        if (xfer) begin
          act_value_d  = ld_value;
          act_blank_d  = ld_blank;
          act_bright_d = ld_bright;
          state_d      = SCAN;
          slot_d       = '0;
          phase_d      = '0;
        end
      end
      SCAN: begin
        phase_d = phase_q + 1'b1;
        if (&phase_q) begin
          slot_d = slot_q + 1'b1;
        end
        if (lit) begin
          seg_d   = segDecoded;
          digit_d = DIGIT_CODE[slot_q];
        end
        frame_done_d = boundary;
        if (xfer) begin
          sh_value_d  = ld_value;
          sh_blank_d  = ld_blank;
          sh_bright_d = ld_bright;
          sh_full_d   = 1'b1;
        end else if (boundary && sh_full_q) begin
          act_value_d  = sh_value_q;
          act_blank_d  = sh_blank_q;
          act_bright_d = sh_bright_q;
          sh_full_d    = 1'b0;
        end
      end
      default: begin
        state_d = BLANK;
      end
    endcase
  end

  // State register. Reset drops any pending shadow load and returns the
  // display to dark.
  always_ff @(posedge clkdigit) begin
    if (reset) begin
      state_q      <= BLANK;
      slot_q       <= '0;
      phase_q      <= '0;
      act_value_q  <= '0;
      act_blank_q  <= '0;
      act_bright_q <= '0;
      sh_value_q   <= '0;
      sh_blank_q   <= '0;
      sh_bright_q  <= '0;
      sh_full_q    <= 1'b0;
      seg_q        <= SEG_OFF;
      digit_q      <= DIGIT_OFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      phase_q      <= phase_d;
      act_value_q  <= act_value_d;
      act_blank_q  <= act_blank_d;
      act_bright_q <= act_bright_d;
      sh_value_q   <= sh_value_d;
      sh_blank_q   <= sh_blank_d;
      sh_bright_q  <= sh_bright_d;
      sh_full_q    <= sh_full_d;
      seg_q        <= seg_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign ld_ready   = ~sh_full_q;
  assign SEG        = seg_q;
  assign DIGIT      = digit_q;
  assign frame_done = frame_done_q;

endmodule
